// File: rtl/pipe_cla_adder.sv
// Pipelined adder/subtractor built from 4-bit carry-lookahead groups. Groups are
// spread over STAGES register stages and carry ripples from group to group.
module pipe_cla_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ofl,
    output logic             Zero
);

    localparam int unsigned NG = WIDTH / 4;
    // Operand registers only feed later stages, so the last stage needs none.
    localparam int unsigned PD = (STAGES > 1) ? STAGES - 1 : 1;

    function automatic int unsigned stage_of(input int unsigned g);
        return (g * STAGES) / NG;
    endfunction

    // Returns {carry into bit 3, group carry out, 4-bit sum}.
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] gn;
        logic [3:0] c;
        logic       gg;
        logic       pg;
        p    = a ^ b;
        gn   = a & b;
        c[0] = ci;
        c[1] = gn[0] | (p[0] & ci);
        c[2] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & ci);
        c[3] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0]) | (p[2] & p[1] & p[0] & ci);
        gg   = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1]) | (p[3] & p[2] & p[1] & gn[0]);
        pg   = &p;
        return {c[3], gg | (pg & ci), p ^ c};
    endfunction

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] cmsb_q, cmsb_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [PD];
    logic [WIDTH-1:0]  a_d   [PD];
    logic [WIDTH-1:0]  b_q   [PD];
    logic [WIDTH-1:0]  b_d   [PD];
    logic              ofl_q, ofl_d;
    logic              zero_q, zero_d;
    logic [STAGES-1:0] load_en;

    // A stage loads when empty or when its contents leave in the same cycle.
    always_comb begin : enable_comb
        logic nxt;
        load_en = '0;
        nxt     = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            load_en[k] = ~valid_q[k] | nxt;
            nxt        = load_en[k];
        end
    end

    always_comb begin : stage_comb
        logic [WIDTH-1:0] a_v;
        logic [WIDTH-1:0] b_v;
        logic [WIDTH-1:0] s_v;
        logic             c_v;
        logic             cm_v;
        logic             v_v;
        logic [5:0]       r_v;
        int unsigned      rk;
        int unsigned      wk;
        valid_d = valid_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        ofl_d   = ofl_q;
        zero_d  = zero_q;
        for (int unsigned k = 0; k < STAGES; k++) sum_d[k] = sum_q[k];
        for (int unsigned k = 0; k < PD; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
        end
        a_v  = '0;
        b_v  = '0;
        s_v  = '0;
        c_v  = 1'b0;
        cm_v = 1'b0;
        v_v  = 1'b0;
        r_v  = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            rk = (k == 0) ? 0 : k - 1;
            wk = (k < PD) ? k : 0;
            if (k == 0) begin
                a_v  = inA;
                b_v  = sub ? ~inB : inB;
                c_v  = sub | Cin;
                s_v  = '0;
                cm_v = 1'b0;
                v_v  = in_valid;
            end else begin
                a_v  = a_q[rk];
                b_v  = b_q[rk];
                c_v  = carry_q[rk];
                s_v  = sum_q[rk];
                cm_v = cmsb_q[rk];
                v_v  = valid_q[rk];
            end
            for (int unsigned g = 0; g < NG; g++) begin
                if (stage_of(g) == k) begin
                    r_v            = cla4(a_v[4*g +: 4], b_v[4*g +: 4], c_v);
                    s_v[4*g +: 4]  = r_v[3:0];
                    c_v            = r_v[4];
                    if (g == NG - 1) cm_v = r_v[5];
                end
            end
            if (load_en[k]) begin
                valid_d[k] = v_v;
                carry_d[k] = c_v;
                cmsb_d[k]  = cm_v;
                sum_d[k]   = s_v;
                if (k + 1 < STAGES) begin
                    a_d[wk] = a_v;
                    b_d[wk] = b_v;
                end
                if (k == STAGES - 1) begin
                    ofl_d  = cm_v ^ c_v;
                    zero_d = (s_v == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            cmsb_q  <= '0;
            ofl_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) sum_q[k] <= '0;
            for (int unsigned k = 0; k < PD; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            ofl_q   <= ofl_d;
            zero_q  <= zero_d;
            for (int unsigned k = 0; k < STAGES; k++) sum_q[k] <= sum_d[k];
            for (int unsigned k = 0; k < PD; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    assign in_ready  = load_en[0];
    assign out_valid = valid_q[STAGES-1];
    assign Sum       = sum_q[STAGES-1];
    assign Cout      = carry_q[STAGES-1];
    assign Ofl       = ofl_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed and streaming bench for pipe_cla_adder: default 16/2 instance plus
// 8/1 and 32/8 instances for the parameter corners.
module tb_pipe_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, Ofl, Zero;
    logic [15:0] inA, inB, Sum;

    logic        s8_in_valid, s8_in_ready, s8_Cin, s8_sub, s8_out_valid, s8_out_ready;
    logic        s8_Cout, s8_Ofl, s8_Zero;
    logic [7:0]  s8_inA, s8_inB, s8_Sum;

    logic        s32_in_valid, s32_in_ready, s32_Cin, s32_sub, s32_out_valid, s32_out_ready;
    logic        s32_Cout, s32_Ofl, s32_Zero;
    logic [31:0] s32_inA, s32_inB, s32_Sum;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_cla_adder #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .Cin(Cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Ofl(Ofl), .Zero(Zero)
    );

    pipe_cla_adder #(.WIDTH(8), .STAGES(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .inA(s8_inA), .inB(s8_inB), .Cin(s8_Cin), .sub(s8_sub), .out_valid(s8_out_valid),
        .out_ready(s8_out_ready), .Sum(s8_Sum), .Cout(s8_Cout), .Ofl(s8_Ofl), .Zero(s8_Zero)
    );

    pipe_cla_adder #(.WIDTH(32), .STAGES(8)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(s32_in_valid), .in_ready(s32_in_ready),
        .inA(s32_inA), .inB(s32_inB), .Cin(s32_Cin), .sub(s32_sub), .out_valid(s32_out_valid),
        .out_ready(s32_out_ready), .Sum(s32_Sum), .Cout(s32_Cout), .Ofl(s32_Ofl), .Zero(s32_Zero)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; inA = 16'h1111; inB = 16'h0001;
        Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, Sum, Cout, Ofl, Zero, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hold: got v=%b sum=%h c/o/z=%b rdy=%b, want v=0 sum=0000 c/o/z=000 rdy=1",
                     out_valid, Sum, {Cout, Ofl, Zero}, in_ready);
        end
        n_cmp++;
        if ({s8_out_valid, s8_Sum, s32_out_valid, s32_Sum, s8_in_ready, s32_in_ready}
                !== {1'b0, 8'h00, 1'b0, 32'h0, 2'b11}) begin
            n_fail++;
            $display("FAIL reset_sweep: got v8=%b s8=%h v32=%b s32=%h rdy=%b%b, want 0 00 0 0 11",
                     s8_out_valid, s8_Sum, s32_out_valid, s32_Sum, s8_in_ready, s32_in_ready);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [8] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h1234, 16'h8000, 16'h1234, 16'h0010, 16'h8000};
        logic [15:0] tb [8] = '{16'h0001, 16'h0001, 16'h0007, 16'h4321, 16'h0001, 16'h1234, 16'h0001, 16'h8000};
        logic [7:0]  tc     = 8'b0100_1000;   // Cin per vector, bit i = vector i
        logic [7:0]  ts     = 8'b0111_0100;   // sub per vector
        logic [15:0] es [8] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h5556, 16'h7FFF, 16'h0000, 16'h000F, 16'h0000};
        logic [2:0]  ef [8] = '{3'b101, 3'b010, 3'b000, 3'b000, 3'b110, 3'b101, 3'b100, 3'b111};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            inA = ta[i]; inB = tb[i]; Cin = tc[i]; sub = ts[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_early[%0d]: got out_valid=%b one edge too early, want 0", i, out_valid);
            end
            @(negedge clk);
            n_cmp++;
            if ({out_valid, Sum, Cout, Ofl, Zero} !== {1'b1, es[i], ef[i]}) begin
                n_fail++;
                $display("FAIL dir[%0d]: got v=%b sum=%h c/o/z=%b, want v=1 sum=%h c/o/z=%b",
                         i, out_valid, Sum, {Cout, Ofl, Zero}, es[i], ef[i]);
            end
        end
    endtask

    task automatic test_stream();
        logic [18:0] exp_q [$];
        logic [18:0] e;
        logic [15:0] a, b, beff;
        logic        c, s, ceff, ofl;
        logic [16:0] t;
        int          recv    = 0;
        int          gaps    = 0;
        bit          started = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 102; i++) begin
            @(posedge clk); #1;
            if (i < 100) begin
                a = 16'($urandom); b = 16'($urandom);
                c = (i % 3 == 0) ? 1'b1 : 1'($urandom);
                s = (i % 4 == 1) ? 1'b0 : 1'($urandom);
                inA = a; inB = b; Cin = c; sub = s; in_valid = 1'b1;
                beff = s ? ~b : b;
                ceff = s ? 1'b1 : c;
                t    = {1'b0, a} + {1'b0, beff} + 17'(ceff);
                ofl  = (a[15] == beff[15]) && (t[15] != a[15]);
                exp_q.push_back({t[16], ofl, (t[15:0] == 16'h0), t[15:0]});
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 100) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_rdy[%0d]: got in_ready=%b, want 1", i, in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                started = 1;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got unexpected result sum=%h, want none", Sum);
                end else begin
                    e = exp_q.pop_front();
                    recv++;
                    if ({Cout, Ofl, Zero, Sum} !== e) begin
                        n_fail++;
                        $display("FAIL stream[%0d]: got c/o/z=%b sum=%h, want c/o/z=%b sum=%h",
                                 recv - 1, {Cout, Ofl, Zero}, Sum, e[18:16], e[15:0]);
                    end
                end
            end else if (started && exp_q.size() != 0) begin
                gaps++;
            end
        end
        n_cmp++;
        if (recv !== 100 || gaps !== 0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d results with %0d gaps, want 100 with 0", recv, gaps);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        out_ready = 1'b0; inA = 16'h0001; inB = 16'h0001; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_rdy1: got in_ready=%b, want 1", in_ready);
        end
        @(posedge clk); #1;
        inA = 16'h0010; inB = 16'h0020;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_rdy2: got in_ready=%b, want 1", in_ready);
        end
        @(posedge clk); #1;
        inA = 16'h0100; inB = 16'h0001; sub = 1'b1;
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready, out_valid, Sum, Cout, Zero} !== {1'b0, 1'b1, 16'h0002, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b sum=%h, want rdy=0 v=1 sum=0002",
                         h, in_ready, out_valid, Sum);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_simul: got in_ready=%b while draining full pipe, want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; sub = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, Sum} !== {1'b1, 16'h0030}) begin
            n_fail++; $display("FAIL bp_out2: got v=%b sum=%h, want v=1 sum=0030", out_valid, Sum);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, Sum, Cout} !== {1'b1, 16'h00FF, 1'b1}) begin
            n_fail++; $display("FAIL bp_out3: got v=%b sum=%h c=%b, want v=1 sum=00ff c=1", out_valid, Sum, Cout);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        @(posedge clk); #1;
        inA = 16'h0003; inB = 16'h0004; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        inA = 16'h0005; inB = 16'h0006;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, Sum, Cout, Ofl, Zero, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b sum=%h c/o/z=%b rdy=%b, want v=0 sum=0000 c/o/z=000 rdy=1",
                     out_valid, Sum, {Cout, Ofl, Zero}, in_ready);
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_flush[%0d]: got out_valid=%b sum=%h, want 0", c, out_valid, Sum);
            end
        end
        @(posedge clk); #1;
        inA = 16'h00AA; inB = 16'h0055; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, Sum} !== {1'b1, 16'h00FF}) begin
            n_fail++; $display("FAIL rst_first: got v=%b sum=%h, want v=1 sum=00ff", out_valid, Sum);
        end
    endtask

    task automatic test_sweep_w8();
        s8_out_ready = 1'b1;
        @(posedge clk); #1;
        s8_inA = 8'hFF; s8_inB = 8'h01; s8_Cin = 1'b0; s8_sub = 1'b0; s8_in_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({s8_out_valid, s8_Sum, s8_Cout, s8_Ofl, s8_Zero} !== {1'b1, 8'h00, 3'b101}) begin
            n_fail++;
            $display("FAIL w8_wrap: got v=%b sum=%h c/o/z=%b, want v=1 sum=00 c/o/z=101",
                     s8_out_valid, s8_Sum, {s8_Cout, s8_Ofl, s8_Zero});
        end
        s8_inA = 8'h80; s8_inB = 8'h01; s8_sub = 1'b1;
        @(posedge clk); #1;
        s8_in_valid = 1'b0;
        n_cmp++;
        if ({s8_out_valid, s8_Sum, s8_Cout, s8_Ofl, s8_Zero} !== {1'b1, 8'h7F, 3'b110}) begin
            n_fail++;
            $display("FAIL w8_min: got v=%b sum=%h c/o/z=%b, want v=1 sum=7f c/o/z=110",
                     s8_out_valid, s8_Sum, {s8_Cout, s8_Ofl, s8_Zero});
        end
    endtask

    task automatic test_sweep_w32();
        logic [31:0] va [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] es [2] = '{32'h0000_0000, 32'h7FFF_FFFF};
        logic [2:0]  ef [2] = '{3'b101, 3'b110};
        int          edges;
        s32_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            s32_inA = va[i]; s32_inB = 32'h1; s32_Cin = 1'b0; s32_sub = (i == 1); s32_in_valid = 1'b1;
            @(posedge clk); #1;
            s32_in_valid = 1'b0;
            edges = 0;
            while (s32_out_valid !== 1'b1 && edges < 20) begin
                @(posedge clk); #1;
                edges++;
            end
            n_cmp++;
            if (edges !== 7) begin
                n_fail++; $display("FAIL w32_lat[%0d]: got %0d extra edges, want 7", i, edges);
            end
            n_cmp++;
            if ({s32_out_valid, s32_Sum, s32_Cout, s32_Ofl, s32_Zero} !== {1'b1, es[i], ef[i]}) begin
                n_fail++;
                $display("FAIL w32_val[%0d]: got v=%b sum=%h c/o/z=%b, want v=1 sum=%h c/o/z=%b",
                         i, s32_out_valid, s32_Sum, {s32_Cout, s32_Ofl, s32_Zero}, es[i], ef[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; inA = '0; inB = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        s8_in_valid = 1'b0; s8_inA = '0; s8_inB = '0; s8_Cin = 1'b0; s8_sub = 1'b0; s8_out_ready = 1'b1;
        s32_in_valid = 1'b0; s32_inA = '0; s32_inB = '0; s32_Cin = 1'b0; s32_sub = 1'b0; s32_out_ready = 1'b1;
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_reset_midflight();
        test_sweep_w8();
        test_sweep_w32();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be a multiple of 4, range 4..64.
REQ-002 Parameter STAGES, default 2: pipeline register stages; SHALL satisfy 1 <= STAGES <= WIDTH/4.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream operand set valid.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 inA  input  WIDTH  operand A.
REQ-009 inB  input  WIDTH  operand B.
REQ-010 Cin  input  1  carry-in; used only when sub=0.
REQ-011 sub  input  1  1 = subtract (A - B), 0 = add (A + B + Cin).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 Sum  output  WIDTH  result.
REQ-015 Cout  output  1  carry out of the MSB; in subtract mode, 1 = no borrow.
REQ-016 Ofl  output  1  two's-complement signed overflow.
REQ-017 Zero  output  1  1 when Sum == 0.

Function
REQ-018 Operand transform: Beff = sub ? ~inB : inB; ceff = sub ? 1 : Cin.
REQ-019 Grouping: the datapath SHALL split into NG = WIDTH/4 four-bit carry-lookahead groups. Each group computes per-bit generate/propagate and group P/G, and derives internal carries by lookahead, not ripple. Carry SHALL ripple group to group.
REQ-020 Stage partition: group g SHALL be evaluated in stage floor(g*STAGES/NG).
REQ-021 Stage registers: each stage register SHALL hold valid, the inter-stage carry, the completed low Sum bits, the unprocessed upper Aeff/Beff bits, sign bits A[MSB]/Beff[MSB], and the group carry into the MSB.
REQ-022 Output stage: Sum, Cout, Ofl and Zero SHALL be driven from the final stage register; no combinational path from inputs to outputs.
REQ-023 Ofl SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-024 Latency: with out_ready held high, a transfer accepted at edge N SHALL have out_valid=1 with its result after edge N+STAGES-1.
REQ-025 Throughput: the block SHALL sustain one transfer per cycle with out_ready continuously high.
REQ-026 Handshake: a transfer occurs on a rising edge when valid && ready. in_ready SHALL depend only on register state and out_ready (no dependency on in_valid).
REQ-027 Stage enable: stage k loads when it is empty or its contents move to stage k+1 (or out to downstream, for the last stage) in the same cycle.
REQ-028 in_ready SHALL equal the stage-0 load enable.
REQ-029 Backpressure: with out_ready=0, the block SHALL hold at most STAGES results. Sum, Cout, Ofl, Zero and out_valid SHALL stay stable until accepted. No transfer is lost, duplicated or reordered.
REQ-030 Simultaneous events: when the pipeline is full and out_ready=1, a new input SHALL be accepted in the same cycle the output drains (in_ready=1).
REQ-031 Bubbles: an empty stage SHALL pass valid=0 and SHALL NOT produce out_valid.
REQ-032 Wrap-around: addition is modulo 2^WIDTH; Cout reports the lost carry.

Reset
REQ-033 While rst_n=0, all stage valid bits and out_valid SHALL be 0, and Sum, Cout, Ofl and Zero SHALL be 0, asynchronously and regardless of clk.
REQ-034 in_ready SHALL be 1 once reset is applied, including while held in reset; transfers attempted during reset SHALL be discarded.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight transfers; the first post-reset result SHALL come from a post-reset input.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-036 inA=0xFFFF, inB=0x0001, Cin=0, sub=0 -> Sum=0x0000, Cout=1, Ofl=0, Zero=1, one edge after acceptance.
REQ-037 inA=0x7FFF, inB=0x0001, sub=0 -> Sum=0x8000, Cout=0, Ofl=1, Zero=0; inA=0x0005, inB=0x0007, sub=1, Cin=0 -> Sum=0xFFFE, Cout=0, Ofl=0.
REQ-038 Streaming: 100 back-to-back random transfers with out_ready=1 -> one result per cycle, in order, matching a reference model, including Cin=1 cases.
REQ-039 Backpressure: out_ready=0, feed 3 transfers -> in_ready=0 after 2 are accepted. Raise out_ready -> outputs 1,2,3 in order, each held stable until accepted.
REQ-040 Reset mid-flight: 2 transfers in flight, pulse rst_n low between clock edges -> out_valid=0 immediately, Sum=0, nothing emitted after release.
REQ-041 Parameter sweep: (WIDTH=8, STAGES=1) gives latency 0 extra edges, and (WIDTH=32, STAGES=8) gives 7 edges; both carry corner cases 0xFF..F+1 and MIN-1 with correct Ofl.
